// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with show-ahead read, watermarks, sticky errors and flush.
// Define FIFO_PEAK_EN to build the high-water-mark register; otherwise peak is tied to 0.
module fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    input  logic              flush,
    input  logic              clr_err,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W:0]   peak
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_V    = (ADDR_W+1)'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   count_next;
    logic              push_ok;
    logic              pop_ok;
    logic              ov_set;
    logic              un_set;

    always_comb begin
        push_ok    = 1'b0;
        pop_ok     = 1'b0;
        ov_set     = 1'b0;
        un_set     = 1'b0;
        count_next = '0;
        if (!flush) begin
            push_ok    = push & (~full | pop);
            pop_ok     = pop & ~empty;
            ov_set     = push & full & ~pop;
            un_set     = pop & empty;
            count_next = count + {{ADDR_W{1'b0}}, push_ok} - {{ADDR_W{1'b0}}, pop_ok};
        end
    end

    // When full, w_ptr == r_ptr, so a simultaneous push lands in the slot being popped.
    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem[w_ptr] <= push_data;
    end

    assign pop_data = mem[r_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                if (push_ok) w_ptr <= w_ptr + 1'b1;
                if (pop_ok)  r_ptr <= r_ptr + 1'b1;
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_V);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_V);
            almost_empty <= (count_next <= AE_V);
            overflow     <= ov_set | (overflow & ~clr_err);
            underflow    <= un_set | (underflow & ~clr_err);
        end
    end

`ifdef FIFO_PEAK_EN
    logic [ADDR_W:0] peak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak_q <= '0;
        else if (clr_err || (count_next > peak_q))
            peak_q <= count_next;
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed scoreboard bench for fifo_param (DATA_W=8, ADDR_W=4, AF_LVL=12, AE_LVL=2).
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] pop_data;
    logic       flush;
    logic       clr_err;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic [4:0] peak;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    int         m_count = 0;
    int         m_peak  = 0;
    logic       m_ov    = 1'b0;
    logic       m_un    = 1'b0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LVL(12), .AE_LVL(2)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .flush(flush), .clr_err(clr_err), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .peak(peak)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int exp_peak;
`ifdef FIFO_PEAK_EN
        exp_peak = m_peak;
`else
        exp_peak = 0;
`endif
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == 16));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("almost_full", 32'(almost_full), 32'(m_count >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
        chk("peak", 32'(peak), 32'(exp_peak));
    endtask

    task automatic model_reset();
        q.delete();
        m_count = 0;
        m_peak  = 0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
    endtask

    // One clock: drive, check head word before the edge, update model, check status after.
    task automatic cyc(input logic p, input logic [7:0] d, input logic o,
                       input logic f, input logic c);
        logic pok, ook, ovs, uns;
        int   cn;
        push = p; push_data = d; pop = o; flush = f; clr_err = c;
        if (o && !f && q.size() > 0)
            chk("pop_data", 32'(pop_data), 32'(q[0]));
        pok = !f && p && (m_count < 16 || o);
        ook = !f && o && (m_count > 0);
        ovs = !f && p && (m_count == 16) && !o;
        uns = !f && o && (m_count == 0);
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
            cn = 0;
        end else begin
            if (ook) void'(q.pop_front());
            if (pok) q.push_back(d);
            cn = m_count + int'(pok) - int'(ook);
        end
        m_ov = ovs || (m_ov && !c);
        m_un = uns || (m_un && !c);
        if (c || cn > m_peak) m_peak = cn;
        m_count = cn;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        check_status();
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) cyc(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; push_data = '0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_status();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: fill 0x01..0x10, watermarks tracked every cycle, then drain in order
        fill(8'h01);
        drain(16);

        // 2: simultaneous push/pop while full
        fill(8'h20);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        drain(16);

        // 3: overflow, then clr_err
        fill(8'h40);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain(16);

        // 4: push/pop on empty -> push accepted, underflow
        cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        drain(1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 5: 20 pushes / 20 pops interleaved across pointer wrap
        for (int i = 0; i < 4; i++)  cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 4; i < 20; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0);
        drain(4);

        // 6: flush with push keeps error flags; then async reset mid-burst
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        drain(1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
        push = 1'b1; push_data = 8'hF0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_status();
        push = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_status();
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
